// File: rtl/clic_pkg.sv
// Shared CLIC types: interrupt id/priority, stack entry payload and dispatch FSM states.
// Shared by the arbitration tree and the dispatch side.
package clic_pkg;

  localparam int unsigned INT_AMOUNT = 8;
  localparam int unsigned PRIORITIES = 4;
  localparam int unsigned INT_ID_W   = $clog2(INT_AMOUNT);

  typedef logic [PRIORITIES-1:0] IntPrio;
  typedef logic [INT_ID_W-1:0]   IntId;

  typedef struct packed {
    IntPrio prio;
    IntId   id;
  } stack_entry_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } dispatch_state_t;

endpackage

// File: rtl/clic_prio_stack.sv
// LIFO of accepted interrupts.
// A pop and a push in the same cycle pop first, then push. Top and depth are registered.
module clic_prio_stack
  import clic_pkg::*;
#(
  parameter int unsigned Depth  = 4,
  parameter int unsigned DepthW = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  stack_entry_t      push_data,
  output stack_entry_t      top,
  output logic [DepthW-1:0] depth
);

  stack_entry_t      mem [Depth];
  logic [DepthW-1:0] popped_cnt;
  logic [DepthW-1:0] next_cnt;
  logic              do_push;
  stack_entry_t      below_top;
  stack_entry_t      next_top;

  // Apply the pop first, then the push onto the reduced stack.
  always_comb begin
    popped_cnt = depth;
    if (pop && (depth != '0)) begin
      popped_cnt = depth - DepthW'(1);
    end
    below_top = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (DepthW'(i + 1) == popped_cnt) begin
        below_top = mem[i];
      end
    end
    do_push  = push && (popped_cnt < DepthW'(Depth));
    next_cnt = popped_cnt;
    next_top = below_top;
    if (do_push) begin
      next_cnt = popped_cnt + DepthW'(1);
      next_top = push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth <= '0;
      top   <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      depth <= next_cnt;
      top   <= next_top;
      for (int unsigned i = 0; i < Depth; i++) begin
        if (do_push && (DepthW'(i) == popped_cnt)) begin
          mem[i] <= push_data;
        end
      end
    end
  end

endmodule

// File: rtl/clic_dispatch.sv
// CLIC dispatch: preemption decision, valid/ready offer to the core, pending clear, nesting stack.
// Define CLIC_NEST_EN for a StackDepth-deep preemption stack; otherwise a single active level.
module clic_dispatch
  import clic_pkg::*;
#(
  parameter int unsigned IntAmount  = INT_AMOUNT,
  parameter int unsigned Priorities = PRIORITIES,
  parameter int unsigned StackDepth = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [$clog2(IntAmount)-1:0]       pend_id,
  input  logic [Priorities-1:0]              pend_prio,
  output logic                               irq_valid,
  output logic [$clog2(IntAmount)-1:0]       irq_id,
  output logic [Priorities-1:0]              irq_prio,
  input  logic                               irq_ready,
  input  logic                               done,
  output logic                               clr_pend,
  output logic [$clog2(IntAmount)-1:0]       clr_id,
  output logic [Priorities-1:0]              cur_prio,
  output logic [$clog2(StackDepth+1)-1:0]    depth,
  output logic                               err
);

  localparam int unsigned ID_W    = $clog2(IntAmount);
  localparam int unsigned PRIO_W  = Priorities;
  localparam int unsigned DEPTH_W = $clog2(StackDepth + 1);
`ifdef CLIC_NEST_EN
  localparam int unsigned EFF_DEPTH = StackDepth;
`else
  localparam int unsigned EFF_DEPTH = 1;
`endif

  dispatch_state_t state;
  logic            accept;
  logic            room;
  stack_entry_t    push_entry;
  stack_entry_t    stack_top;

  assign accept     = (state == S_REQ) && irq_ready;
  assign room       = depth < DEPTH_W'(EFF_DEPTH);
  assign push_entry = '{prio: PRIORITIES'(irq_prio), id: INT_ID_W'(irq_id)};
  assign cur_prio   = PRIO_W'(stack_top.prio);

  clic_prio_stack #(
    .Depth  (EFF_DEPTH),
    .DepthW (DEPTH_W)
  ) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .pop       (done),
    .push_data (push_entry),
    .top       (stack_top),
    .depth     (depth)
  );

  // Offer is frozen once raised: no upgrade and no retraction until the core accepts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
      irq_prio  <= '0;
      clr_pend  <= 1'b0;
      clr_id    <= '0;
      err       <= 1'b0;
    end else begin
      clr_pend <= 1'b0;
      if (done && (depth == '0)) begin
        err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if ((pend_prio > cur_prio) && room) begin
            irq_id    <= ID_W'(pend_id);
            irq_prio  <= PRIO_W'(pend_prio);
            irq_valid <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (irq_ready) begin
            irq_valid <= 1'b0;
            clr_pend  <= 1'b1;
            clr_id    <= irq_id;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clic_dispatch.sv
// Directed bench for clic_dispatch; expected requests and pending clears go through scoreboard queues.
// Follows the CLIC_NEST_EN setting of the build.
module tb_clic_dispatch;
  import clic_pkg::*;

  localparam int unsigned SD      = 4;
  localparam int unsigned ID_W    = $clog2(INT_AMOUNT);
  localparam int unsigned PRIO_W  = PRIORITIES;
  localparam int unsigned DEPTH_W = $clog2(SD + 1);

  logic               clk = 1'b0;
  logic               reset_n;
  logic [ID_W-1:0]    pend_id;
  logic [PRIO_W-1:0]  pend_prio;
  logic               irq_valid;
  logic [ID_W-1:0]    irq_id;
  logic [PRIO_W-1:0]  irq_prio;
  logic               irq_ready;
  logic               done;
  logic               clr_pend;
  logic [ID_W-1:0]    clr_id;
  logic [PRIO_W-1:0]  cur_prio;
  logic [DEPTH_W-1:0] depth;
  logic               err;

  int total = 0;
  int bad   = 0;

  stack_entry_t req_q[$];
  IntId         clr_q[$];
  stack_entry_t last_req;

  clic_dispatch #(
    .IntAmount  (INT_AMOUNT),
    .Priorities (PRIORITIES),
    .StackDepth (SD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pend_id   (pend_id),
    .pend_prio (pend_prio),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_prio  (irq_prio),
    .irq_ready (irq_ready),
    .done      (done),
    .clr_pend  (clr_pend),
    .clr_id    (clr_id),
    .cur_prio  (cur_prio),
    .depth     (depth),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int prio, input int id);
    pend_prio = PRIO_W'(prio);
    pend_id   = ID_W'(id);
  endtask

  task automatic expect_req_push(input int prio, input int id);
    stack_entry_t e;
    e.prio = IntPrio'(prio);
    e.id   = IntId'(id);
    req_q.push_back(e);
  endtask

  // Compare the current offer against the oldest expected request.
  task automatic expect_req(input string tag);
    chk({tag, "_valid"}, int'(irq_valid), 1);
    chk({tag, "_qlen"}, req_q.size(), 1);
    if (req_q.size() > 0) begin
      last_req = req_q.pop_front();
      chk({tag, "_id"}, int'(irq_id), int'(last_req.id));
      chk({tag, "_prio"}, int'(irq_prio), int'(last_req.prio));
    end
  endtask

  task automatic accept(input string tag);
    clr_q.push_back(last_req.id);
    irq_ready = 1'b1;
    tick(1);
    irq_ready = 1'b0;
    chk({tag, "_valid_drop"}, int'(irq_valid), 0);
    chk({tag, "_clr_pend"}, int'(clr_pend), 1);
    chk({tag, "_clr_id"}, int'(clr_id), int'(clr_q.pop_front()));
    tick(1);
    chk({tag, "_clr_pulse"}, int'(clr_pend), 0);
  endtask

  task automatic no_req(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (irq_valid !== 1'b0) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick(1);
    done = 1'b0;
  endtask

  task automatic chk_level(input string tag, input int d, input int p);
    chk({tag, "_depth"}, int'(depth), d);
    chk({tag, "_cur"}, int'(cur_prio), p);
  endtask

  initial begin
    reset_n   = 1'b0;
    irq_ready = 1'b0;
    done      = 1'b0;
    drive(0, 0);
    tick(2);
    chk("rst_valid", int'(irq_valid), 0);
    chk("rst_clr", int'(clr_pend), 0);
    chk("rst_err", int'(err), 0);
    chk_level("rst", 0, 0);
    reset_n = 1'b1;

    no_req("prio0_none", 5);

    // Basic request, freeze while waiting, accept.
    drive(2, 5);
    expect_req_push(2, 5);
    tick(1);
    expect_req("t1");
    drive(9, 1);
    tick(3);
    chk("t1_hold_valid", int'(irq_valid), 1);
    chk("t1_hold_id", int'(irq_id), 5);
    chk("t1_hold_prio", int'(irq_prio), 2);
    drive(0, 0);
    accept("t1");
    chk_level("t1_after", 1, 2);

`ifdef CLIC_NEST_EN
    drive(2, 4);
    no_req("eq_prio", 20);
    drive(1, 4);
    no_req("low_prio", 20);
    drive(3, 2);
    expect_req_push(3, 2);
    tick(1);
    expect_req("t2");
    drive(0, 0);
    accept("t2");
    chk_level("t2_nest", 2, 3);
    pulse_done();
    chk_level("t2_pop1", 1, 2);
    pulse_done();
    chk_level("t2_pop2", 0, 0);

    // Fill the stack with increasing priorities.
    for (int k = 0; k < 4; k++) begin
      drive(k + 1, k);
      expect_req_push(k + 1, k);
      tick(1);
      expect_req("fill");
      drive(0, 0);
      accept("fill");
    end
    chk_level("full", 4, 4);
    drive(15, 7);
    no_req("full_block", 10);
    pulse_done();
    chk_level("full_pop", 3, 3);
    chk("full_pop_valid", int'(irq_valid), 0);
    expect_req_push(15, 7);
    tick(1);
    expect_req("t4");
    drive(0, 0);
    pulse_done();
    chk_level("req_pop", 2, 2);
    chk("req_pop_valid", int'(irq_valid), 1);
    chk("req_pop_id", int'(irq_id), 7);

    // done and accept together: pop, then push.
    clr_q.push_back(last_req.id);
    irq_ready = 1'b1;
    done      = 1'b1;
    tick(1);
    irq_ready = 1'b0;
    done      = 1'b0;
    chk_level("swap", 2, 15);
    chk("swap_clr", int'(clr_pend), 1);
    chk("swap_clr_id", int'(clr_id), int'(clr_q.pop_front()));
    pulse_done();
    chk_level("drain1", 1, 1);
    pulse_done();
    chk_level("drain2", 0, 0);
    chk("no_err_yet", int'(err), 0);
    pulse_done();
    chk("err_set", int'(err), 1);
    chk_level("err_depth", 0, 0);
`else
    drive(3, 2);
    no_req("nonest_block", 20);
    drive(2, 4);
    no_req("eq_prio", 5);
    drive(3, 2);
    pulse_done();
    chk_level("t2_pop", 0, 0);
    chk("t2_pop_valid", int'(irq_valid), 0);
    expect_req_push(3, 2);
    tick(1);
    expect_req("t2");
    drive(0, 0);
    chk("no_err_yet", int'(err), 0);
    // done and accept together at depth 0: pop ignored (error), push proceeds.
    clr_q.push_back(last_req.id);
    irq_ready = 1'b1;
    done      = 1'b1;
    tick(1);
    irq_ready = 1'b0;
    done      = 1'b0;
    chk("err_set", int'(err), 1);
    chk_level("swap", 1, 3);
    chk("swap_clr", int'(clr_pend), 1);
    chk("swap_clr_id", int'(clr_id), int'(clr_q.pop_front()));
    pulse_done();
    chk_level("drain", 0, 0);
`endif
    pulse_done();
    chk("err_sticky", int'(err), 1);
    chk_level("err_depth0", 0, 0);

    // Asynchronous reset in the middle of an offer.
    drive(5, 6);
    expect_req_push(5, 6);
    tick(1);
    expect_req("pre_rst");
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", int'(irq_valid), 0);
    chk("arst_err", int'(err), 0);
    chk_level("arst", 0, 0);
    drive(0, 0);
    tick(1);
    reset_n = 1'b1;
    no_req("post_rst", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
